// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - default parameters and helpers shared by the fetch stage
package fetch_pkg;

    localparam int DEFAULT_PC_WIDTH    = 8;
    localparam int DEFAULT_INSTR_WIDTH = 16;
    localparam int DEFAULT_PC_STEP     = 4;
    localparam int DEFAULT_QUEUE_DEPTH = 4;
    localparam int DEFAULT_RESET_PC    = 0;

    // Count must represent 0..depth inclusive, hence one bit above the pointer width
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: control, instruction memory port and decode handshake
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH    = DEFAULT_PC_WIDTH,
    parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
    parameter int CW          = count_width(DEFAULT_QUEUE_DEPTH)
);
    logic                   fetchEn;
    logic                   redirectEn;
    logic [PC_WIDTH-1:0]    redirectPc;
    logic [PC_WIDTH-1:0]    imemAddr;
    logic [INSTR_WIDTH-1:0] imemData;
    logic                   instrValid;
    logic                   instrReady;
    logic [INSTR_WIDTH-1:0] instruction;
    logic [PC_WIDTH-1:0]    instrPc;
    logic [CW-1:0]          queueCount;

    modport master (
        input  fetchEn, redirectEn, redirectPc, imemData, instrReady,
        output imemAddr, instrValid, instruction, instrPc, queueCount
    );

    modport slave (
        output fetchEn, redirectEn, redirectPc, imemData, instrReady,
        input  imemAddr, instrValid, instruction, instrPc, queueCount
    );
endinterface

// File: rtl/fetch_unit_queue.sv
// rtl/fetch_unit_queue.sv - synchronous FIFO with flush, used as the prefetch queue
module fetch_queue #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(DEPTH));
    assign count = r_count;
    assign rdata = r_mem[r_head];

    // A push into a full queue is legal when the head leaves in the same cycle
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_tail] <= wdata;
                r_tail        <= r_tail + AW'(1);
            end
            if (w_do_pop) begin
                r_head <= r_head + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, push/redirect control and prefetch queue feeding decode
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH    = DEFAULT_PC_WIDTH,
    parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
    parameter int PC_STEP     = DEFAULT_PC_STEP,
    parameter int QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH,
    parameter int RESET_PC    = DEFAULT_RESET_PC
) (
    input  logic     clk,
    input  logic     reset,
    fetch_if.master  bus
);
    localparam int CW = count_width(QUEUE_DEPTH);
    localparam int EW = INSTR_WIDTH + PC_WIDTH;

    logic [PC_WIDTH-1:0] r_fetch_pc;
    logic                w_pop;
    logic                w_push;
    logic                w_full;
    logic                w_empty;
    logic [EW-1:0]       w_head;
    logic [CW-1:0]       w_count;

    assign w_pop  = ~w_empty & bus.instrReady;
    assign w_push = bus.fetchEn & ~bus.redirectEn & (~w_full | w_pop);

    // PC advances only on an accepted push, so a stalled queue re-presents the same address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= PC_WIDTH'(RESET_PC);
        end else if (bus.redirectEn) begin
            r_fetch_pc <= bus.redirectPc;
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + PC_WIDTH'(PC_STEP);
        end
    end

    fetch_queue #(
        .WIDTH (EW),
        .DEPTH (QUEUE_DEPTH),
        .CW    (CW)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .flush (bus.redirectEn),
        .push  (w_push),
        .pop   (w_pop),
        .wdata ({bus.imemData, r_fetch_pc}),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign bus.imemAddr    = r_fetch_pc;
    assign bus.instrValid  = ~w_empty;
    assign bus.instruction = w_head[EW-1:PC_WIDTH];
    assign bus.instrPc     = w_head[PC_WIDTH-1:0];
    assign bus.queueCount  = w_count;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    fetch_if bus ();

    fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: upper byte is the inverted address so field swaps are visible
    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return {~a, a};
    endfunction

    assign bus.imemData = mem_word(bus.imemAddr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [7:0] pc, input int cnt, input logic [7:0] addr);
        chk({tag, " valid"}, 32'(bus.instrValid), 32'd1);
        chk({tag, " pc"},    32'(bus.instrPc), 32'(pc));
        chk({tag, " instr"}, 32'(bus.instruction), 32'(mem_word(pc)));
        chk({tag, " count"}, 32'(bus.queueCount), 32'(cnt));
        chk({tag, " addr"},  32'(bus.imemAddr), 32'(addr));
    endtask

    initial begin
        logic [7:0] exp_pc;
        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b0;
        bus.fetchEn    = 1'b0;
        bus.redirectEn = 1'b0;
        bus.redirectPc = 8'h00;
        bus.instrReady = 1'b0;
        #2;
        chk("reset valid", 32'(bus.instrValid), 32'd0);
        chk("reset count", 32'(bus.queueCount), 32'd0);
        chk("reset addr",  32'(bus.imemAddr), 32'h00);
        chk("reset instr", 32'(bus.instruction), 32'h0);
        chk("reset pc",    32'(bus.instrPc), 32'h00);

        @(negedge clk);
        reset          = 1'b1;
        bus.fetchEn    = 1'b1;
        bus.instrReady = 1'b1;

        // Streaming: one instruction per cycle, count steady at 1
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_head("stream", 8'(4 * k), 1, 8'(4 * k + 4));
        end

        // Stall decode: queue fills to 4 then PC freezes at 0x1C
        bus.instrReady = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_head("stall", 8'h0C, (k < 3) ? k + 2 : 4, (k < 3) ? 8'(8'h14 + 4 * k) : 8'h1C);
        end

        // Full queue with decode ready: push and pop every cycle, count stays 4
        bus.instrReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_head("fullflow", 8'(8'h10 + 4 * k), 4, 8'(8'h20 + 4 * k));
        end

        // Fetch disabled: queue drains in order while PC holds
        bus.fetchEn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_head("drain", 8'(8'h24 + 4 * k), 3 - k, 8'h30);
        end
        tick();
        chk("drained valid", 32'(bus.instrValid), 32'd0);
        chk("drained count", 32'(bus.queueCount), 32'd0);
        chk("drained addr",  32'(bus.imemAddr), 32'h30);

        // Build count=3, then redirect to 0x40 with a simultaneous pop
        bus.fetchEn    = 1'b1;
        bus.instrReady = 1'b0;
        tick();
        tick();
        tick();
        chk_head("prefill", 8'h30, 3, 8'h3C);
        bus.redirectEn = 1'b1;
        bus.redirectPc = 8'h40;
        bus.instrReady = 1'b1;
        tick();
        chk("redir valid", 32'(bus.instrValid), 32'd0);
        chk("redir count", 32'(bus.queueCount), 32'd0);
        chk("redir addr",  32'(bus.imemAddr), 32'h40);
        bus.redirectEn = 1'b0;
        tick();
        chk_head("redir target", 8'h40, 1, 8'h44);

        // Redirect near the top of the address space to exercise PC wrap
        bus.redirectEn = 1'b1;
        bus.redirectPc = 8'hF8;
        tick();
        chk("wrap redir addr", 32'(bus.imemAddr), 32'hF8);
        bus.redirectEn = 1'b0;
        exp_pc = 8'hF8;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_head("wrap", exp_pc, 1, exp_pc + 8'h04);
            exp_pc = exp_pc + 8'h04;
        end

        // Asynchronous reset mid-stream with two entries queued
        bus.instrReady = 1'b0;
        tick();
        chk_head("pre-reset", 8'h00, 2, 8'h08);
        #2;
        reset = 1'b0;
        #1;
        chk("async valid", 32'(bus.instrValid), 32'd0);
        chk("async count", 32'(bus.queueCount), 32'd0);
        chk("async addr",  32'(bus.imemAddr), 32'h00);
        chk("async pc",    32'(bus.instrPc), 32'h00);
        @(negedge clk);
        reset          = 1'b1;
        bus.instrReady = 1'b1;
        tick();
        chk_head("restart", 8'h00, 1, 8'h04);
        tick();
        chk_head("restart2", 8'h04, 1, 8'h08);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage with a prefetch queue and decoupled decode handshake. It holds the fetch PC, drives a combinational instruction-memory port, and buffers fetched {instruction, PC} pairs in a small FIFO. Decode pops entries with a valid/ready handshake, and a redirect (branch/jump) flushes the queue and reloads the PC. It sits between instruction memory and decode, replacing the fixed-width, always-advancing fetch stage.

## Interface
Parameters:
- PC_WIDTH, 8: fetch PC and address width.
- INSTR_WIDTH, 16: instruction word width.
- PC_STEP, 4: PC increment per fetched instruction.
- QUEUE_DEPTH, 4: prefetch entries; power of two, ≥2.
- RESET_PC, 0: fetch PC after reset.

Ports (CW = $clog2(QUEUE_DEPTH)+1):
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetchEn  in  1  permits new fetches; 0 freezes the PC and pushes, while pops continue.
- redirectEn  in  1  flush-and-redirect request.
- redirectPc  in  PC_WIDTH  new fetch PC when redirectEn=1.
- imemAddr  out  PC_WIDTH  instruction-memory address, equal to the fetch PC.
- imemData  in  INSTR_WIDTH  combinational memory read data for imemAddr.
- instrValid  out  1  queue non-empty.
- instrReady  in  1  decode accepts head entry.
- instruction  out  INSTR_WIDTH  head entry instruction.
- instrPc  out  PC_WIDTH  head entry PC.
- queueCount  out  CW  occupied entries, 0..QUEUE_DEPTH.

## Operation
- pop = instrValid & instrReady.
- push = fetchEn & ~redirectEn & (queueCount<QUEUE_DEPTH | pop).
- On push: the tail entry is written with {imemData, fetchPc}, the tail pointer advances, and fetchPc ← fetchPc+PC_STEP modulo 2^PC_WIDTH.
- On pop: the head pointer advances.
- count' = count + push − pop. Push and pop in the same cycle leave count unchanged, including when full.
- On redirectEn: head, tail and count go to 0, and fetchPc ← redirectPc. Any simultaneous pop is a completed handshake for decode, but it has no further effect. No push happens that cycle.
- Pointers wrap modulo QUEUE_DEPTH. The PC wraps silently (0xFC+4 → 0x00 at defaults).
- instruction and instrPc always show the head slot. When instrValid=0 they hold stale or reset data and are don't-care for decode.
- Reset values: fetchPc=RESET_PC (so imemAddr=RESET_PC), count=0, instrValid=0, pointers=0, storage=0, instruction=0, instrPc=0.
- Reset mid-operation clears everything immediately and asynchronously. Any queued entries are lost.

## Timing
- imemAddr is combinational from the fetchPc register. The imemData → storage path is combinational into the tail write, so the memory must be asynchronous-read.
- Fetch latency: an instruction fetched at edge N is presented with instrValid=1 immediately after edge N. With the queue empty, decode sees it one cycle after the PC was valid.
- Redirect asserted before edge N: after N the queue is empty and imemAddr=redirectPc. After N+1 the target instruction is valid. This is a one-cycle bubble.
- Steady state with instrReady=1: one instruction per cycle, and count stays at 1.
- Full with instrReady=0: fetchPc holds and no writes occur until a pop.
- fetchEn=0: fetchPc holds, and the queue drains via pops.

## Structure
- Package fetch_pkg holds:
  - default parameter constants (PC_WIDTH, INSTR_WIDTH, PC_STEP, QUEUE_DEPTH, RESET_PC);
  - a count-width function.
- Sub-module fetch_queue: parametrised synchronous FIFO with a flush input, exposing push, pop, full, empty and count.
- fetch_unit contains the fetch PC register, the push/redirect logic, and one fetch_queue instance storing {instruction, pc}.

## Test plan
- Reset release, fetchEn=1, instrReady=1, memory word[a]=a: instrPc sequence 0,4,8,… one per cycle, instruction matches, queueCount=1 steady.
- instrReady=0 for 6 cycles: queueCount goes 1,2,3,4 then stays 4. imemAddr freezes at 0x10. Releasing ready drains entries in PC order 0,4,8,C with no loss or duplication.
- Full queue, then instrReady=1 with fetchEn=1: push and pop every cycle, queueCount stays 4, PCs strictly sequential.
- Redirect to 0x40 while count=3 and a pop happens: next cycle count=0, instrValid=0, imemAddr=0x40. The following cycle instrPc=0x40 with instrValid=1.
- fetchPc at 0xFC with PC_STEP=4: next fetched instrPc=0x00, proving wrap.
- Assert reset low mid-stream with count=2: outputs immediately read instrValid=0, queueCount=0, imemAddr=RESET_PC. After release, fetch restarts from RESET_PC.
